// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN layer engines.
//   - fc_state_t        : state encoding of the fully-connected layer FSM
//   - INPUT_SIZE, Lx_*  : element counts of the network input and each layer
//   - ADDR_SIZE         : address width of the per-layer RAMs
//   - round_shift/sat8  : requantization helpers (rounding arithmetic right
//                         shift, then clamp to the int8 range)
// No ports (package).
// ---------------------------------------------------------------------------
package cnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAC,
      ST_LAST,
      ST_WRITE,
      ST_DONE
   } fc_state_t;

   localparam int INPUT_SIZE = 1024;
   localparam int L1_SIZE    = 4608;
   localparam int L2_SIZE    = 1152;
   localparam int L3_SIZE    = 200;
   localparam int L4_SIZE    = 53;

   localparam int L3_N_IN    = L2_SIZE;
   localparam int L3_N_OUT   = L3_SIZE;
   localparam int L4_N_IN    = L3_SIZE;
   localparam int L4_N_OUT   = L4_SIZE;

   localparam int ADDR_SIZE  = 19;

   // Add half an LSB of the result, then shift arithmetically; a zero shift
   // means no rounding term at all. Callers widen to 64 bits first so the
   // rounding add can never wrap.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int sh);
      logic signed [63:0] t;
      t = v;
      if (sh != 0) begin
         t = v + (64'sd1 <<< (sh - 1));
      end
      return t >>> sh;
   endfunction

   // Clamp a wide signed value into [-128, 127].
   function automatic logic signed [7:0] sat8(input logic signed [63:0] v);
      logic signed [7:0] r;
      if (v > 64'sd127) begin
         r = 8'sh7f;
      end else if (v < -64'sd128) begin
         r = 8'sh80;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/fc_layer_if.sv
// ---------------------------------------------------------------------------
// fc_layer_if
// Bundles the control handshake and the three RAM ports of fc_layer.
//   start    : run request (from controller)
//   busy     : run in progress
//   done     : one-cycle completion pulse
//   in_addr  / in_data  : activation RAM read port (1-cycle latency)
//   w_addr   / w_data   : weight RAM read port (1-cycle latency)
//   out_we / out_addr / out_data : output RAM write port
// Modports: slave = the layer engine, master = controller plus RAMs.
// ---------------------------------------------------------------------------
interface fc_layer_if #(
   parameter int ADDR_SIZE = cnn_pkg::ADDR_SIZE
);

   logic                  start;
   logic                  busy;
   logic                  done;
   logic [ADDR_SIZE-1:0]  in_addr;
   logic signed [7:0]     in_data;
   logic [ADDR_SIZE-1:0]  w_addr;
   logic signed [7:0]     w_data;
   logic                  out_we;
   logic [ADDR_SIZE-1:0]  out_addr;
   logic signed [7:0]     out_data;

   modport slave (
      input  start, in_data, w_data,
      output busy, done, in_addr, w_addr, out_we, out_addr, out_data
   );

   modport master (
      output start, in_data, w_data,
      input  busy, done, in_addr, w_addr, out_we, out_addr, out_data
   );

endinterface

// File: rtl/fc_layer_mac.sv
// ---------------------------------------------------------------------------
// fc_mac
// Multiply-accumulate datapath of the fully-connected layer.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_issue      : an address pair was issued to the RAMs this cycle
//   i_clear      : zero the accumulator (start of run / after a write)
//   i_in_data    : signed activation from the activation RAM
//   i_w_data     : signed weight from the weight RAM
//   o_acc        : running signed accumulator
// ---------------------------------------------------------------------------
module fc_mac #(
   parameter int ACC_W = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_issue,
   input  logic                    i_clear,
   input  logic signed [7:0]       i_in_data,
   input  logic signed [7:0]       i_w_data,
   output logic signed [ACC_W-1:0] o_acc
);

   logic                    r_valid;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [15:0]      w_prod;

   assign w_prod = i_in_data * i_w_data;
   assign o_acc  = r_acc;

   // The RAMs answer one cycle after the address, so the issue strobe is
   // delayed by one cycle to mark the cycle in which the data pair is real.
   // Clear wins over accumulate; the FSM never asks for both at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_acc   <= '0;
      end else begin
         r_valid <= i_issue;
         if (i_clear) begin
            r_acc <= '0;
         end else if (r_valid) begin
            r_acc <= r_acc + ACC_W'(w_prod);
         end
      end
   end

endmodule

// File: rtl/fc_layer.sv
// ---------------------------------------------------------------------------
// fc_layer
// Fully-connected layer engine: for every output neuron o it walks the N_IN
// activations and the matching weight row (row-major, o*N_IN+i), accumulates
// the signed int8 products, requantizes to int8 and writes the result to the
// output RAM at address o. A neuron takes N_IN+2 cycles (MAC x N_IN, LAST,
// WRITE); done pulses one cycle after the final write.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : fc_layer_if.slave (start/busy/done, activation, weight and
//                  output RAM ports)
// Build option: define FC_RELU_EN to write negative results as 0.
// ---------------------------------------------------------------------------
module fc_layer #(
   parameter int N_IN      = cnn_pkg::L4_N_IN,
   parameter int N_OUT     = cnn_pkg::L4_N_OUT,
   parameter int ADDR_SIZE = cnn_pkg::ADDR_SIZE,
   parameter int ACC_W     = 32,
   parameter int SHIFT     = 7
) (
   input logic       clk,
   input logic       reset_n,
   fc_layer_if.slave bus
);

   import cnn_pkg::*;

   fc_state_t               r_state;
   fc_state_t               w_nextState;
   logic [ADDR_SIZE-1:0]    r_i;
   logic [ADDR_SIZE-1:0]    r_o;
   logic [ADDR_SIZE-1:0]    r_wa;
   logic                    w_lastIn;
   logic                    w_lastOut;
   logic                    w_issue;
   logic                    w_clear;
   logic signed [ACC_W-1:0] w_acc;
   logic signed [63:0]      w_accExt;
   logic signed [7:0]       w_rq;
   logic signed [7:0]       w_result;

   assign w_lastIn  = (r_i == ADDR_SIZE'(N_IN - 1));
   assign w_lastOut = (r_o == ADDR_SIZE'(N_OUT - 1));

   // Addresses come straight from the counters, so during LAST, WRITE and
   // DONE they simply hold whatever was issued last.
   assign bus.in_addr  = r_i;
   assign bus.w_addr   = r_wa;
   assign bus.out_addr = r_o;

   fc_mac #(
      .ACC_W     (ACC_W)
   ) u_mac (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_issue   (w_issue),
      .i_clear   (w_clear),
      .i_in_data (bus.in_data),
      .i_w_data  (bus.w_data),
      .o_acc     (w_acc)
   );

   // Requantize: widen so the rounding add cannot overflow, round-shift,
   // then clamp to int8.
   assign w_accExt = 64'(w_acc);
   assign w_rq     = sat8(round_shift(w_accExt, SHIFT));

`ifdef FC_RELU_EN
   assign w_result = w_rq[7] ? 8'sd0 : w_rq;
`else
   assign w_result = w_rq;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and output decode. All handshake and write-port outputs are
   // pure functions of the state, so a reset immediately silences them.
   always_comb begin
      w_nextState  = r_state;
      bus.busy     = 1'b1;
      bus.done     = 1'b0;
      bus.out_we   = 1'b0;
      bus.out_data = '0;
      w_issue      = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               w_clear     = 1'b1;
               w_nextState = ST_MAC;
            end
         end
         ST_MAC: begin
            w_issue = 1'b1;
            if (w_lastIn) begin
               w_nextState = ST_LAST;
            end
         end
         ST_LAST: begin
            w_nextState = ST_WRITE;
         end
         ST_WRITE: begin
            bus.out_we   = 1'b1;
            bus.out_data = w_result;
            w_clear      = 1'b1;
            w_nextState  = w_lastOut ? ST_DONE : ST_MAC;
         end
         ST_DONE: begin
            bus.done    = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Address counters. The weight address is a running counter that keeps
   // counting across neurons: the step out of WRITE lands it exactly on the
   // first weight of the next row, which avoids an o*N_IN multiplier.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_i  <= '0;
         r_o  <= '0;
         r_wa <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_i  <= '0;
                  r_o  <= '0;
                  r_wa <= '0;
               end
            end
            ST_MAC: begin
               if (!w_lastIn) begin
                  r_i  <= r_i + 1'b1;
                  r_wa <= r_wa + 1'b1;
               end
            end
            ST_WRITE: begin
               if (!w_lastOut) begin
                  r_i  <= '0;
                  r_o  <= r_o + 1'b1;
                  r_wa <= r_wa + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer.sv
// ---------------------------------------------------------------------------
// tb_fc_layer
// Self-checking bench for fc_layer. Three small instances cover the basic
// dot product (SHIFT=0), saturation (SHIFT=7) and rounding (N_IN=1, SHIFT=7).
// Expected writes are queued when a run is launched and popped by per-instance
// monitors as out_we pulses appear. Cycle numbers count from the cycle in
// which start is sampled (cycle 0).
// ---------------------------------------------------------------------------
module tb_fc_layer;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   logic clk;
   logic reset_n;
   int   edgeCnt = 0;
   int   errors  = 0;
   int   checks  = 0;

   exp_t sbA[$];
   exp_t sbB[$];
   exp_t sbC[$];

   int startA, startB, startC;
   int writesA, writesB, writesC;
   int doneCntA, doneCntB, doneCntC;
   int doneCycA, doneCycB, doneCycC;

   logic signed [7:0] actA [0:3];
   logic signed [7:0] wgtA [0:7];
   logic signed [7:0] actB [0:3];
   logic signed [7:0] wgtB [0:7];
   logic signed [7:0] actC [0:3];
   logic signed [7:0] wgtC [0:3];

   fc_layer_if #(.ADDR_SIZE(19)) aBus ();
   fc_layer_if #(.ADDR_SIZE(19)) bBus ();
   fc_layer_if #(.ADDR_SIZE(19)) cBus ();

   fc_layer #(.N_IN(4), .N_OUT(2), .ADDR_SIZE(19), .ACC_W(32), .SHIFT(0)) dutA (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (aBus.slave)
   );

   fc_layer #(.N_IN(4), .N_OUT(2), .ADDR_SIZE(19), .ACC_W(32), .SHIFT(7)) dutB (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bBus.slave)
   );

   fc_layer #(.N_IN(1), .N_OUT(3), .ADDR_SIZE(19), .ACC_W(32), .SHIFT(7)) dutC (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (cBus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // Synchronous-read RAM models with one cycle of latency.
   always @(posedge clk) begin
      aBus.in_data <= actA[aBus.in_addr[1:0]];
      aBus.w_data  <= wgtA[aBus.w_addr[2:0]];
      bBus.in_data <= actB[bBus.in_addr[1:0]];
      bBus.w_data  <= wgtB[bBus.w_addr[2:0]];
      cBus.in_data <= actC[cBus.in_addr[1:0]];
      cBus.w_data  <= wgtC[cBus.w_addr[1:0]];
   end

   function automatic int relu(input int v);
`ifdef FC_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // Output monitors: every write must match the head of its scoreboard.
   always @(negedge clk) begin : monA
      exp_t e;
      if (aBus.out_we === 1'b1) begin
         writesA++;
         checks++;
         if (sbA.size() == 0) begin
            errors++;
            $display("[TB] FAIL writeA unexpected: addr=%0d data=%0d cycle=%0d, required no write",
                     aBus.out_addr, aBus.out_data, edgeCnt - startA);
         end else begin
            e = sbA.pop_front();
            if (int'(aBus.out_addr) !== e.addr || int'(aBus.out_data) !== e.data ||
                (edgeCnt - startA) !== e.cyc) begin
               errors++;
               $display("[TB] FAIL writeA: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                        aBus.out_addr, aBus.out_data, edgeCnt - startA, e.addr, e.data, e.cyc);
            end
         end
      end
      if (aBus.done === 1'b1) begin
         doneCntA++;
         doneCycA = edgeCnt - startA;
      end
   end

   always @(negedge clk) begin : monB
      exp_t e;
      if (bBus.out_we === 1'b1) begin
         writesB++;
         checks++;
         if (sbB.size() == 0) begin
            errors++;
            $display("[TB] FAIL writeB unexpected: addr=%0d data=%0d cycle=%0d, required no write",
                     bBus.out_addr, bBus.out_data, edgeCnt - startB);
         end else begin
            e = sbB.pop_front();
            if (int'(bBus.out_addr) !== e.addr || int'(bBus.out_data) !== e.data ||
                (edgeCnt - startB) !== e.cyc) begin
               errors++;
               $display("[TB] FAIL writeB: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                        bBus.out_addr, bBus.out_data, edgeCnt - startB, e.addr, e.data, e.cyc);
            end
         end
      end
      if (bBus.done === 1'b1) begin
         doneCntB++;
         doneCycB = edgeCnt - startB;
      end
   end

   always @(negedge clk) begin : monC
      exp_t e;
      if (cBus.out_we === 1'b1) begin
         writesC++;
         checks++;
         if (sbC.size() == 0) begin
            errors++;
            $display("[TB] FAIL writeC unexpected: addr=%0d data=%0d cycle=%0d, required no write",
                     cBus.out_addr, cBus.out_data, edgeCnt - startC);
         end else begin
            e = sbC.pop_front();
            if (int'(cBus.out_addr) !== e.addr || int'(cBus.out_data) !== e.data ||
                (edgeCnt - startC) !== e.cyc) begin
               errors++;
               $display("[TB] FAIL writeC: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                        cBus.out_addr, cBus.out_data, edgeCnt - startC, e.addr, e.data, e.cyc);
            end
         end
      end
      if (cBus.done === 1'b1) begin
         doneCntC++;
         doneCycC = edgeCnt - startC;
      end
   end

   // Start pulses: raised at a falling edge so the next rising edge samples it
   // (that cycle is cycle 0); returns at the falling edge of cycle 1.
   task automatic pulseStartA();
      writesA = 0; doneCntA = 0; doneCycA = -1;
      @(negedge clk);
      aBus.start = 1'b1;
      startA = edgeCnt;
      @(negedge clk);
      aBus.start = 1'b0;
   endtask

   task automatic pulseStartB();
      writesB = 0; doneCntB = 0; doneCycB = -1;
      @(negedge clk);
      bBus.start = 1'b1;
      startB = edgeCnt;
      @(negedge clk);
      bBus.start = 1'b0;
   endtask

   task automatic pulseStartC();
      writesC = 0; doneCntC = 0; doneCycC = -1;
      @(negedge clk);
      cBus.start = 1'b1;
      startC = edgeCnt;
      @(negedge clk);
      cBus.start = 1'b0;
   endtask

   task automatic loadBasicA();
      for (int k = 0; k < 4; k++) actA[k] = 8'(k + 1);
      for (int k = 0; k < 8; k++) wgtA[k] = (k < 4) ? 8'sd1 : -8'sd1;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      aBus.start = 1'b0;
      bBus.start = 1'b0;
      cBus.start = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (aBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b, required 0", aBus.busy); end
      checks++; if (aBus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b, required 0", aBus.done); end
      checks++; if (aBus.out_we !== 1'b0) begin errors++; $display("[TB] FAIL reset out_we: got %b, required 0", aBus.out_we); end
      checks++; if (aBus.in_addr !== 19'd0) begin errors++; $display("[TB] FAIL reset in_addr: got %0d, required 0", aBus.in_addr); end
      checks++; if (aBus.w_addr !== 19'd0) begin errors++; $display("[TB] FAIL reset w_addr: got %0d, required 0", aBus.w_addr); end
      checks++; if (aBus.out_addr !== 19'd0) begin errors++; $display("[TB] FAIL reset out_addr: got %0d, required 0", aBus.out_addr); end
      checks++; if (aBus.out_data !== 8'sd0) begin errors++; $display("[TB] FAIL reset out_data: got %0d, required 0", aBus.out_data); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      loadBasicA();
      sbA.push_back('{0, 10, 6});
      sbA.push_back('{1, relu(-10), 12});
      pulseStartA();
      repeat (20) @(negedge clk);
      checks++; if (doneCntA !== 1) begin errors++; $display("[TB] FAIL basic done count: got %0d, required 1", doneCntA); end
      checks++; if (doneCycA !== 13) begin errors++; $display("[TB] FAIL basic done cycle: got %0d, required 13", doneCycA); end
      checks++; if (writesA !== 2) begin errors++; $display("[TB] FAIL basic write count: got %0d, required 2", writesA); end
      checks++; if (sbA.size() !== 0) begin errors++; $display("[TB] FAIL basic pending writes: got %0d, required 0", sbA.size()); sbA.delete(); end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 4; k++) actB[k] = 8'sd127;
      for (int k = 0; k < 8; k++) wgtB[k] = (k < 4) ? 8'sd127 : 8'sh80;
      sbB.push_back('{0, 127, 6});
      sbB.push_back('{1, relu(-128), 12});
      pulseStartB();
      repeat (20) @(negedge clk);
      checks++; if (doneCntB !== 1) begin errors++; $display("[TB] FAIL sat done count: got %0d, required 1", doneCntB); end
      checks++; if (doneCycB !== 13) begin errors++; $display("[TB] FAIL sat done cycle: got %0d, required 13", doneCycB); end
      checks++; if (writesB !== 2) begin errors++; $display("[TB] FAIL sat write count: got %0d, required 2", writesB); end
      checks++; if (sbB.size() !== 0) begin errors++; $display("[TB] FAIL sat pending writes: got %0d, required 0", sbB.size()); sbB.delete(); end
   endtask

   task automatic test_rounding();
      // 96*2=192 -> 2, 96*1=96 -> 1, 96*-1=-96 -> -1 (floor after rounding)
      for (int k = 0; k < 4; k++) actC[k] = 8'sd96;
      wgtC[0] = 8'sd2; wgtC[1] = 8'sd1; wgtC[2] = -8'sd1; wgtC[3] = 8'sd0;
      sbC.push_back('{0, 2, 3});
      sbC.push_back('{1, 1, 6});
      sbC.push_back('{2, relu(-1), 9});
      pulseStartC();
      repeat (14) @(negedge clk);
      checks++; if (doneCntC !== 1) begin errors++; $display("[TB] FAIL round1 done count: got %0d, required 1", doneCntC); end
      checks++; if (doneCycC !== 10) begin errors++; $display("[TB] FAIL round1 done cycle: got %0d, required 10", doneCycC); end
      checks++; if (writesC !== 3) begin errors++; $display("[TB] FAIL round1 write count: got %0d, required 3", writesC); end
      checks++; if (sbC.size() !== 0) begin errors++; $display("[TB] FAIL round1 pending writes: got %0d, required 0", sbC.size()); sbC.delete(); end
      // 127 -> 1, 63 -> 0, 64 -> 1 (exact half rounds up)
      for (int k = 0; k < 4; k++) actC[k] = 8'sd1;
      wgtC[0] = 8'sd127; wgtC[1] = 8'sd63; wgtC[2] = 8'sd64;
      sbC.push_back('{0, 1, 3});
      sbC.push_back('{1, 0, 6});
      sbC.push_back('{2, 1, 9});
      pulseStartC();
      repeat (14) @(negedge clk);
      checks++; if (doneCntC !== 1) begin errors++; $display("[TB] FAIL round2 done count: got %0d, required 1", doneCntC); end
      checks++; if (doneCycC !== 10) begin errors++; $display("[TB] FAIL round2 done cycle: got %0d, required 10", doneCycC); end
      checks++; if (writesC !== 3) begin errors++; $display("[TB] FAIL round2 write count: got %0d, required 3", writesC); end
      checks++; if (sbC.size() !== 0) begin errors++; $display("[TB] FAIL round2 pending writes: got %0d, required 0", sbC.size()); sbC.delete(); end
   endtask

   task automatic test_start_ignored();
      loadBasicA();
      sbA.push_back('{0, 10, 6});
      sbA.push_back('{1, relu(-10), 12});
      pulseStartA();
      for (int c = 2; c <= 20; c++) begin
         @(negedge clk);
         aBus.start = (c == 3 || c == 8);
      end
      aBus.start = 1'b0;
      checks++; if (doneCntA !== 1) begin errors++; $display("[TB] FAIL busy-start done count: got %0d, required 1", doneCntA); end
      checks++; if (doneCycA !== 13) begin errors++; $display("[TB] FAIL busy-start done cycle: got %0d, required 13", doneCycA); end
      checks++; if (writesA !== 2) begin errors++; $display("[TB] FAIL busy-start write count: got %0d, required 2", writesA); end
      checks++; if (sbA.size() !== 0) begin errors++; $display("[TB] FAIL busy-start pending writes: got %0d, required 0", sbA.size()); sbA.delete(); end
   endtask

   task automatic test_reset_midrun();
      loadBasicA();
      sbA.push_back('{0, 10, 6});
      pulseStartA();
      for (int c = 2; c <= 11; c++) @(negedge clk);
      reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (aBus.out_we !== 1'b0) begin errors++; $display("[TB] FAIL midreset out_we: got %b, required 0", aBus.out_we); end
         checks++; if (aBus.done !== 1'b0) begin errors++; $display("[TB] FAIL midreset done: got %b, required 0", aBus.done); end
         checks++; if (aBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset busy: got %b, required 0", aBus.busy); end
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (writesA !== 1) begin errors++; $display("[TB] FAIL midreset write count: got %0d, required 1", writesA); end
      checks++; if (doneCntA !== 0) begin errors++; $display("[TB] FAIL midreset done count: got %0d, required 0", doneCntA); end
      checks++; if (sbA.size() !== 0) begin errors++; $display("[TB] FAIL midreset pending writes: got %0d, required 0", sbA.size()); sbA.delete(); end
      sbA.push_back('{0, 10, 6});
      sbA.push_back('{1, relu(-10), 12});
      pulseStartA();
      repeat (20) @(negedge clk);
      checks++; if (doneCntA !== 1) begin errors++; $display("[TB] FAIL rerun done count: got %0d, required 1", doneCntA); end
      checks++; if (doneCycA !== 13) begin errors++; $display("[TB] FAIL rerun done cycle: got %0d, required 13", doneCycA); end
      checks++; if (writesA !== 2) begin errors++; $display("[TB] FAIL rerun write count: got %0d, required 2", writesA); end
      checks++; if (sbA.size() !== 0) begin errors++; $display("[TB] FAIL rerun pending writes: got %0d, required 0", sbA.size()); sbA.delete(); end
   endtask

   initial begin
      writesA = 0; writesB = 0; writesC = 0;
      doneCntA = 0; doneCntB = 0; doneCntC = 0;
      doneCycA = -1; doneCycB = -1; doneCycC = -1;
      startA = 0; startB = 0; startC = 0;
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_start_ignored();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
